// File: rtl/alu_issue_queue.sv
// Issue queue in front of the 12-bit-instruction ALU: buffers host instructions in a small FIFO,
// issues them one at a time with a start pulse, and returns {cb, result} or a timeout error.
module alu_issue_queue #(
    parameter int INSTR_LENGTH = 12,
    parameter int DEPTH        = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INSTR_LENGTH-1:0]   in_instr,
    output logic                      start,
    output logic [INSTR_LENGTH-1:0]   instruction,
    input  logic                      rvalid,
    input  logic [3:0]                result,
    input  logic                      cb,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4:0]                out_data,
    output logic                      out_err,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t                  state_reg, state_next;
    logic [PW-1:0]           wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]           count_reg, count_next;
    logic [INSTR_LENGTH-1:0] instr_reg, instr_next;
    logic                    start_reg, start_next;
    logic                    out_valid_reg, out_valid_next;
    logic [4:0]              out_data_reg, out_data_next;
    logic                    out_err_reg, out_err_next;
    logic [TW-1:0]           timer_reg, timer_next;

    logic                    push, pop;
    logic [INSTR_LENGTH-1:0] entries [DEPTH];

    // in_ready is held low while reset is asserted so nothing is offered during reset.
    assign in_ready = reset_n && (count_reg != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state_reg == IDLE) && (count_reg != '0);

    // Storage has no reset: only the pointers and count define what is valid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [INSTR_LENGTH-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PW'(gi)))
                    entry_reg <= in_instr;
            end
            assign entries[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        instr_next     = instr_reg;
        start_next     = 1'b0;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_err_next   = out_err_reg;
        timer_next     = timer_reg;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    instr_next = entries[rd_ptr_reg];
                    start_next = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                timer_next = '0;
                state_next = WAIT;
            end
            WAIT: begin
                // rvalid takes priority over an expiring timer in the same cycle.
                if (rvalid) begin
                    out_data_next  = {cb, result};
                    out_err_next   = 1'b0;
                    out_valid_next = 1'b1;
                    state_next     = HOLD;
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    out_data_next  = '0;
                    out_err_next   = 1'b1;
                    out_valid_next = 1'b1;
                    state_next     = HOLD;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            instr_reg     <= '0;
            start_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_err_reg   <= 1'b0;
            timer_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            instr_reg     <= instr_next;
            start_reg     <= start_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_err_reg   <= out_err_next;
            timer_reg     <= timer_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    assign start       = start_reg;
    assign instruction = instr_reg;
    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign out_err     = out_err_reg;
    assign count       = count_reg;

endmodule
